ac_match_ctrl: RTL
==================

# ac_match_ctrl

Sequencing controller for Aho-Corasick output-state detection. It accepts automaton state numbers from the transition engine over a valid/ready handshake and scans a runtime-loadable output-state table, one compare per cycle. It stops at the first hit and returns exactly one hit/miss result per accepted state, tagged with the input byte position. It sits between the goto/failure state engine and the match reporting logic, and replaces the combinational all-entries compare with a bounded, configurable sequential scan.

## Interface
- STATE_W, 8: automaton state width
- DEPTH, 32: output-state table entries (power of two)
- POS_W, 16: byte-position counter width
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- EN  in  1  accept enable; low blocks new requests, in-flight scan completes
- IN_VALID  in  1  state request valid
- IN_RDY  out  1  controller can accept
- IN_STATE  in  STATE_W  automaton state to check
- CFG_WE  in  1  table write strobe
- CFG_ADDR  in  log2(DEPTH)  table write address
- CFG_DATA  in  STATE_W  output-state value
- CFG_NUM  in  log2(DEPTH)+1  number of active entries, sampled at accept
- OUT_VALID  out  1  result valid
- OUT_RDY  in  1  consumer accepts result
- OUT_HIT  out  1  1 = state is an output state
- OUT_IDX  out  log2(DEPTH)  index of matching entry (0 on miss)
- OUT_POS  out  POS_W  byte position of the checked state
- BUSY  out  1  high in SCAN or REPORT

## Operation
- FSM states: IDLE, SCAN, REPORT.
- IDLE: IN_RDY = EN. On IN_VALID&IN_RDY, latch IN_STATE, latch min(CFG_NUM, DEPTH) as limit, latch the position counter into OUT_POS, increment the position counter, clear the scan index, and go to SCAN. If the limit is 0, go directly to REPORT with OUT_HIT=0.
- SCAN: compare table[idx] with the latched state. On equality, set OUT_HIT=1 and OUT_IDX=idx, then go to REPORT. Otherwise increment idx. If idx == limit-1, go to REPORT with OUT_HIT=0 and OUT_IDX=0.
- REPORT: OUT_VALID=1. OUT_* are held stable until OUT_RDY. On OUT_VALID&OUT_RDY, go to IDLE.
- Entry value all-ones (0xFF) is reserved as invalid and never matches, even when IN_STATE is 0xFF.
- CFG_WE is honoured only in IDLE. Writes in SCAN or REPORT are dropped, so the table is stable during a scan.
- The position counter wraps from 2^POS_W-1 to 0. It counts accepted requests only.
- Reset values:
  - FSM = IDLE
  - IN_RDY follows EN
  - OUT_VALID=0, OUT_HIT=0, OUT_IDX=0, OUT_POS=0, BUSY=0
  - position counter 0
  - all table entries 0xFF

## Timing
- Accept in cycle 0. The compare of entry k occurs in cycle k+1.
- Hit at entry k: OUT_VALID is first high in cycle k+2.
- Miss: OUT_VALID is first high in cycle limit+1. With limit 0, OUT_VALID is high in cycle 1.
- IN_RDY is low from the cycle after accept until the cycle after the OUT handshake. There is no overlap between requests.
- Maximum throughput: one request per limit+2 cycles when OUT_RDY is held high.
- EN falling during SCAN or REPORT does not abort. The result is still delivered.
- Asserting RST mid-scan immediately returns the block to reset values, and the pending result is discarded.

## Configuration
- MATCH_CNT_EN defined: adds input CNT_CLR (1) and output HIT_CNT (16).
  - HIT_CNT increments on each OUT handshake with OUT_HIT=1.
  - HIT_CNT saturates at 0xFFFF.
  - Synchronous CNT_CLR zeroes it. If a hit handshake occurs in the same cycle, clear wins.
  - HIT_CNT resets to 0.
- MATCH_CNT_EN undefined: CNT_CLR and HIT_CNT do not exist, and no counter logic is present.

## Test plan
- Reset check: assert RST low mid-SCAN -> outputs go to reset values at once. After release, request state 0x05 with table empty (CFG_NUM=4) -> miss, OUT_VALID in cycle 5, OUT_POS=0.
- Table hit: load {0x03,0x07,0x0C,0x11}, CFG_NUM=4, send 0x0C -> OUT_HIT=1, OUT_IDX=2, OUT_VALID in cycle 4.
- Boundaries:
  - CFG_NUM=0 -> miss in cycle 1.
  - CFG_NUM=40 -> limit clamped to 32.
  - IN_STATE=0xFF against an unwritten table -> miss.
- Backpressure: hold OUT_RDY low 10 cycles -> OUT_* stable, IN_RDY low. CFG_WE during the stall has no effect on a later scan.
- Position wrap: after 65535 accepted requests, next two give OUT_POS=0xFFFF then 0x0000. EN low -> IN_RDY low, no accept.
- With MATCH_CNT_EN: 3 hits -> HIT_CNT=3. Hit handshake with CNT_CLR in the same cycle -> HIT_CNT=0.

Source files
------------

// File: rtl/ac_match_ctrl.sv
// Aho-Corasick output-state detector: sequential scan of a loadable state table, one compare/cycle.
// Optional saturating hit counter (CNT_CLR / HIT_CNT) enabled by defining MATCH_CNT_EN.
module ac_match_ctrl #(
  parameter int unsigned StateW = 8,
  parameter int unsigned Depth  = 32,
  parameter int unsigned PosW   = 16,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned LimW  = AddrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              in_valid_i,
  output logic              in_rdy_o,
  input  logic [StateW-1:0] in_state_i,
  input  logic              cfg_we_i,
  input  logic [AddrW-1:0]  cfg_addr_i,
  input  logic [StateW-1:0] cfg_data_i,
  input  logic [LimW-1:0]   cfg_num_i,
  output logic              out_valid_o,
  input  logic              out_rdy_i,
  output logic              out_hit_o,
  output logic [AddrW-1:0]  out_idx_o,
  output logic [PosW-1:0]   out_pos_o,
`ifdef MATCH_CNT_EN
  input  logic              cnt_clr_i,
  output logic [15:0]       hit_cnt_o,
`endif
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  state_e              state_q;
  logic [StateW-1:0]   tab_q [Depth];
  logic [StateW-1:0]   key_q;
  logic [LimW-1:0]     limit_q;
  logic [AddrW-1:0]    idx_q;
  logic [PosW-1:0]     pos_q;
  logic                out_valid_q;
  logic                out_hit_q;
  logic [AddrW-1:0]    out_idx_q;
  logic [PosW-1:0]     out_pos_q;

  logic                accept;
  logic [LimW-1:0]     limit_clamped;
  logic [StateW-1:0]   entry;
  logic                entry_hit;
  logic                last_entry;

  assign accept        = (state_q == StIdle) && en_i && in_valid_i;
  assign limit_clamped = (cfg_num_i > LimW'(Depth)) ? LimW'(Depth) : cfg_num_i;
  assign entry         = tab_q[idx_q];
  // All-ones entries mark unused slots and must never report a hit.
  assign entry_hit     = (entry == key_q) && (entry != {StateW{1'b1}});
  assign last_entry    = ({1'b0, idx_q} == (limit_q - LimW'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      key_q       <= '0;
      limit_q     <= '0;
      idx_q       <= '0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      out_pos_q   <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        tab_q[i] <= '1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_we_i) begin
            tab_q[cfg_addr_i] <= cfg_data_i;
          end
          if (accept) begin
            key_q     <= in_state_i;
            limit_q   <= limit_clamped;
            out_pos_q <= pos_q;
            pos_q     <= pos_q + PosW'(1);
            idx_q     <= '0;
            out_hit_q <= 1'b0;
            out_idx_q <= '0;
            if (limit_clamped == '0) begin
              state_q     <= StReport;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StScan;
            end
          end
        end
        StScan: begin
          if (entry_hit) begin
            out_hit_q   <= 1'b1;
            out_idx_q   <= idx_q;
            state_q     <= StReport;
            out_valid_q <= 1'b1;
          end else if (last_entry) begin
            state_q     <= StReport;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + AddrW'(1);
          end
        end
        StReport: begin
          if (out_rdy_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_rdy_o    = (state_q == StIdle) && en_i;
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = out_valid_q;
  assign out_hit_o   = out_hit_q;
  assign out_idx_o   = out_idx_q;
  assign out_pos_o   = out_pos_q;

`ifdef MATCH_CNT_EN
  logic [15:0] hit_cnt_q;

  // Clear takes priority over a coincident hit handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      hit_cnt_q <= '0;
    end else if (out_valid_q && out_rdy_i && out_hit_q && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_q <= hit_cnt_q + 16'd1;
    end
  end

  assign hit_cnt_o = hit_cnt_q;
`endif

endmodule
